// File: rtl/ebus_arb_if.sv
// EBUS arbiter signal bundle: requests, transfer handshake and grant/status lines.
// The slave modport is the arbiter; the master modport is the requester/device side.
interface ebus_arb_if;
  logic CON_REQ;
  logic CP_REQ;
  logic CP_REL;
  logic PI_REQ;
  logic START;
  logic XFER;
  logic CON_GRANT;
  logic CP_GRANT;
  logic PI_GRANT;
  logic DEMAND;
  logic XFER_DONE;
  logic TIMEOUT;
  logic BUSY;

  modport slave (
    input  CON_REQ, CP_REQ, CP_REL, PI_REQ, START, XFER,
    output CON_GRANT, CP_GRANT, PI_GRANT, DEMAND, XFER_DONE, TIMEOUT, BUSY
  );

  modport master (
    output CON_REQ, CP_REQ, CP_REL, PI_REQ, START, XFER,
    input  CON_GRANT, CP_GRANT, PI_GRANT, DEMAND, XFER_DONE, TIMEOUT, BUSY
  );
endinterface

// File: rtl/ebus_arb.sv
// KL10 EBUS arbiter: fixed-priority grant (CON > CP > PI) plus the
// demand/transfer handshake with hold time and acknowledge timeout.
module ebus_arb #(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int HOLD_CYCLES    = 2
) (
  input logic       clk,
  input logic       RESET,
  ebus_arb_if.slave bus
);

  localparam int MAXC = (TIMEOUT_CYCLES > HOLD_CYCLES) ? TIMEOUT_CYCLES : HOLD_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);
  localparam logic [CW-1:0] TLAST = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] HLAST = CW'(HOLD_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, GRANTED, DEM, HOLD, GAP} state_t;

  state_t        state_q;
  logic          conGrant_q;
  logic          cpGrant_q;
  logic          piGrant_q;
  logic          demand_q;
  logic          xferDone_q;
  logic          timeout_q;
  logic          relPend_q;
  logic [CW-1:0] cnt_q;

  logic relNow;
  logic endToGap;
  logic [CW-1:0] cntInc;

  // A release seen on the closing edge itself still counts for that transaction.
  always_comb begin
    relNow   = (conGrant_q & ~bus.CON_REQ) | (cpGrant_q & bus.CP_REL);
    endToGap = relPend_q | relNow | piGrant_q;
    cntInc   = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (RESET) begin
      state_q    <= IDLE;
      conGrant_q <= 1'b0;
      cpGrant_q  <= 1'b0;
      piGrant_q  <= 1'b0;
      demand_q   <= 1'b0;
      xferDone_q <= 1'b0;
      timeout_q  <= 1'b0;
      relPend_q  <= 1'b0;
      cnt_q      <= '0;
    end else begin
      xferDone_q <= 1'b0;
      timeout_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.CON_REQ) begin
            conGrant_q <= 1'b1;
            state_q    <= GRANTED;
          end else if (bus.CP_REQ) begin
            cpGrant_q <= 1'b1;
            state_q   <= GRANTED;
          end else if (bus.PI_REQ) begin
            piGrant_q <= 1'b1;
            state_q   <= GRANTED;
          end
        end
        GRANTED: begin
          if (bus.START) begin
            state_q   <= DEM;
            demand_q  <= 1'b1;
            cnt_q     <= '0;
            relPend_q <= relNow;
          end else if (relNow) begin
            state_q    <= GAP;
            conGrant_q <= 1'b0;
            cpGrant_q  <= 1'b0;
            piGrant_q  <= 1'b0;
          end
        end
        DEM: begin
          relPend_q <= relPend_q | relNow;
          if (bus.XFER) begin
            state_q <= HOLD;
            cnt_q   <= '0;
          end else if (cnt_q == TLAST) begin
            demand_q  <= 1'b0;
            timeout_q <= 1'b1;
            relPend_q <= 1'b0;
            if (endToGap) begin
              state_q    <= GAP;
              conGrant_q <= 1'b0;
              cpGrant_q  <= 1'b0;
              piGrant_q  <= 1'b0;
            end else begin
              state_q <= GRANTED;
            end
          end else begin
            cnt_q <= cntInc;
          end
        end
        HOLD: begin
          relPend_q <= relPend_q | relNow;
          if (cnt_q == HLAST) begin
            demand_q   <= 1'b0;
            xferDone_q <= 1'b1;
            relPend_q  <= 1'b0;
            if (endToGap) begin
              state_q    <= GAP;
              conGrant_q <= 1'b0;
              cpGrant_q  <= 1'b0;
              piGrant_q  <= 1'b0;
            end else begin
              state_q <= GRANTED;
            end
          end else begin
            cnt_q <= cntInc;
          end
        end
        GAP: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.CON_GRANT = conGrant_q;
  assign bus.CP_GRANT  = cpGrant_q;
  assign bus.PI_GRANT  = piGrant_q;
  assign bus.DEMAND    = demand_q;
  assign bus.XFER_DONE = xferDone_q;
  assign bus.TIMEOUT   = timeout_q;
  assign bus.BUSY      = (state_q != IDLE);

endmodule
